// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/load-store) arbiter onto one shared memory bus; optional ARB_ROUND_ROBIN_EN
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              i_stall,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner;
    logic              r_inst_done;
    logic              r_data_done;
    logic [31:0]       r_inst_rdata;
    logic [31:0]       r_data_rdata;
    logic              r_bus_wr;
    logic [3:0]        r_bus_wstrb;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_wdata;
`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_grant;
`endif

    logic w_inst_pend;
    logic w_data_pend;
    logic w_grant;
    logic w_grant_owner;
    logic w_complete;
    logic w_bus_req;

    // A requester that already completed stays masked until the pipeline advances
    assign w_inst_pend = inst_req & ~r_inst_done;
    assign w_data_pend = data_req & ~r_data_done;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, hand the bus to whoever did not get it last time
    assign w_grant_owner = (w_inst_pend & w_data_pend) ? ~r_last_grant : w_data_pend;
`else
    // Loads/stores always beat fetches on a tie
    assign w_grant_owner = w_data_pend;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, bus request and completion decode
    always_comb begin
        w_next_state = r_state;
        w_bus_req    = 1'b0;
        w_grant      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_inst_pend | w_data_pend) begin
                    w_grant      = 1'b1;
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                w_bus_req = 1'b1;
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        w_complete   = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    w_complete   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Latch the granted request, capture read data and track per-port completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= OWN_INST;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
            r_inst_rdata <= 32'd0;
            r_data_rdata <= 32'd0;
            r_bus_wr     <= 1'b0;
            r_bus_wstrb  <= 4'd0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= 32'd0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_owner;
                if (w_grant_owner == OWN_DATA) begin
                    r_bus_wr    <= data_wr;
                    r_bus_wstrb <= data_wstrb;
                    r_bus_addr  <= data_addr;
                    r_bus_wdata <= data_wdata;
                end else begin
                    r_bus_wr    <= 1'b0;
                    r_bus_wstrb <= 4'd0;
                    r_bus_addr  <= inst_addr;
                    r_bus_wdata <= 32'd0;
                end
            end
            if (w_complete) begin
                if (r_owner == OWN_INST) begin
                    r_inst_rdata <= bus_rdata;
                end else if (!r_bus_wr) begin
                    r_data_rdata <= bus_rdata;
                end
            end
            // Setting on completion wins over the pipeline-advance clear
            r_inst_done <= (w_complete & (r_owner == OWN_INST)) | (r_inst_done & longest_stall);
            r_data_done <= (w_complete & (r_owner == OWN_DATA)) | (r_data_done & longest_stall);
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the most recent grant for tie-breaking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= OWN_INST;
        end else if (w_grant) begin
            r_last_grant <= w_grant_owner;
        end
    end
`endif

    assign i_stall    = w_inst_pend;
    assign d_stall    = w_data_pend;
    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;
    assign bus_req    = w_bus_req;
    assign bus_wr     = r_bus_wr;
    assign bus_wstrb  = r_bus_wstrb;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .i_stall       (i_stall),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_wstrb    (data_wstrb),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .bus_req       (bus_req),
        .bus_wr        (bus_wr),
        .bus_wstrb     (bus_wstrb),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_addr_ok   (bus_addr_ok),
        .bus_data_ok   (bus_data_ok),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0; longest_stall = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;

        // Reset state
        step(); step();
        check("rst_bus_req",    {31'd0, bus_req}, 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        check("rst_bus_addr",   bus_addr, 32'd0);
        check("rst_bus_wdata",  bus_wdata, 32'd0);
        check("rst_stalls",     {30'd0, i_stall, d_stall}, 32'd0);
        rst = 1'b0;
        step();

        // Minimum-latency fetch
        inst_req = 1'b1; inst_addr = 32'hBFC00000; settle();
        check("f_c0_istall", {31'd0, i_stall}, 32'd1);
        check("f_c0_busreq", {31'd0, bus_req}, 32'd0);
        step();
        bus_addr_ok = 1'b1; settle();
        check("f_c1_busreq",  {31'd0, bus_req}, 32'd1);
        check("f_c1_busaddr", bus_addr, 32'hBFC00000);
        check("f_c1_buswr",   {31'd0, bus_wr}, 32'd0);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24080001; settle();
        check("f_c2_busreq", {31'd0, bus_req}, 32'd0);
        check("f_c2_istall", {31'd0, i_stall}, 32'd1);
        step();
        bus_data_ok = 1'b0; settle();
        check("f_c3_istall", {31'd0, i_stall}, 32'd0);
        check("f_c3_rdata",  inst_rdata, 32'h24080001);
        inst_req = 1'b0;
        step();
        check("f_c4_busreq", {31'd0, bus_req}, 32'd0);

        // Simultaneous requests: load served before fetch
        inst_req = 1'b1; inst_addr = 32'h00001000;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00002000; settle();
        check("b_c0_stalls", {30'd0, i_stall, d_stall}, 32'd3);
        step();
        bus_addr_ok = 1'b1; settle();
        check("b_c1_addr_data", bus_addr, 32'h00002000);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA5555; settle();
        check("b_c2_istall", {31'd0, i_stall}, 32'd1);
        step();
        bus_data_ok = 1'b0; settle();
        check("b_c3_drdata", data_rdata, 32'hAAAA5555);
        check("b_c3_dstall", {31'd0, d_stall}, 32'd0);
        check("b_c3_istall", {31'd0, i_stall}, 32'd1);
        data_req = 1'b0;
        step();
        bus_addr_ok = 1'b1; settle();
        check("b_c4_addr_inst", bus_addr, 32'h00001000);
        check("b_c4_busreq",    {31'd0, bus_req}, 32'd1);
        check("b_c4_istall",    {31'd0, i_stall}, 32'd1);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11112222; settle();
        check("b_c5_istall", {31'd0, i_stall}, 32'd1);
        step();
        bus_data_ok = 1'b0; settle();
        check("b_c6_istall", {31'd0, i_stall}, 32'd0);
        check("b_c6_irdata", inst_rdata, 32'h11112222);
        check("b_c6_drdata", data_rdata, 32'hAAAA5555);
        inst_req = 1'b0;
        step();

        // Store with a slow address phase
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3;
        data_wdata = 32'hDEADBEEF; data_addr = 32'h00003000;
        step();
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("s_wait%0d_busreq", i), {31'd0, bus_req}, 32'd1);
            check($sformatf("s_wait%0d_wdata", i), bus_wdata, 32'hDEADBEEF);
            step();
        end
        bus_addr_ok = 1'b1; settle();
        check("s_buswr",    {31'd0, bus_wr}, 32'd1);
        check("s_buswstrb", {28'd0, bus_wstrb}, 32'h3);
        check("s_busaddr",  bus_addr, 32'h00003000);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678; settle();
        check("s_data_busreq", {31'd0, bus_req}, 32'd0);
        step();
        bus_data_ok = 1'b0; settle();
        check("s_dstall", {31'd0, d_stall}, 32'd0);
        check("s_drdata", data_rdata, 32'hAAAA5555);
        data_req = 1'b0;
        step();

        // Same-cycle addr/data ok, then pipeline held by longest_stall
        longest_stall = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00004000;
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D; settle();
        check("l_busreq", {31'd0, bus_req}, 32'd1);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; settle();
        check("l_drdata", data_rdata, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("l_hold%0d_dstall", i), {31'd0, d_stall}, 32'd0);
            check($sformatf("l_hold%0d_busreq", i), {31'd0, bus_req}, 32'd0);
            if (i < 2) begin
                step();
            end
        end
        longest_stall = 1'b0;
        step();
        check("l_release_dstall", {31'd0, d_stall}, 32'd1);
        data_req = 1'b0;
        step();
        check("l_release_busreq", {31'd0, bus_req}, 32'd0);

        // Reset in the middle of a fetch data phase
        inst_req = 1'b1; inst_addr = 32'h00005000;
        step();
        bus_addr_ok = 1'b1;
        step();
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        rst = 1'b1; #2; rst = 1'b0; settle();
        check("r_busreq_now", {31'd0, bus_req}, 32'd0);
        check("r_irdata_now", inst_rdata, 32'd0);
        step();
        bus_data_ok = 1'b1; bus_rdata = 32'hFFFFFFFF;
        step();
        bus_data_ok = 1'b0; settle();
        check("r_irdata_after", inst_rdata, 32'd0);
        check("r_drdata_after", data_rdata, 32'd0);
        check("r_busreq_after", {31'd0, bus_req}, 32'd0);
        step();
        check("r_idle_busreq", {31'd0, bus_req}, 32'd0);

`ifdef ARB_ROUND_ROBIN_EN
        // Continuous contention alternates DATA, INST, DATA
        inst_req = 1'b1; inst_addr = 32'h00001000;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h00002000;
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; settle();
        check("rr_g0_data", bus_addr, 32'h00002000);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; settle();
        check("rr_idle0", {31'd0, bus_req}, 32'd0);
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; settle();
        check("rr_g1_inst", bus_addr, 32'h00001000);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; settle();
        check("rr_idle1", {31'd0, bus_req}, 32'd0);
        step();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; settle();
        check("rr_g2_data", bus_addr, 32'h00002000);
        step();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        inst_req = 1'b0; data_req = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
